// File: rtl/stack_cmd_frontend.sv
// stack_cmd_frontend
// Command/response front end for an external LIFO stack. Accepts NOP, PUSH
// and POP commands on a valid/ready channel, issues single-cycle Push/Pop
// strobes to the stack, and returns one response per non-NOP command.
// Illegal requests (PUSH when Full, POP when Empty, op 11) get an error
// response with zero data and no strobe.
//
// Optional feature: define STACK_CMD_ERRCNT_EN to add the saturating 8-bit
// err_cnt output, which counts responses entered with a non-zero error code.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | cmd_ready high, waiting for a command
// PUSH_ISS | Push strobe high for this one cycle, Data_In holds the operand
// POP_ISS  | Pop strobe high for this one cycle
// POP_CAP  | stack read data is valid; captured into resp_data at the edge
// RESP     | response presented, held stable until resp_ready

module stack_cmd_frontend #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          RstN,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [DW-1:0] cmd_data,
    output logic          resp_valid,
    input  logic          resp_ready,
    output logic [DW-1:0] resp_data,
    output logic [1:0]    resp_err,
    output logic          Push,
    output logic          Pop,
    output logic [DW-1:0] Data_In,
    input  logic [DW-1:0] Data_Out,
    input  logic          Full,
    input  logic          Empty
`ifdef STACK_CMD_ERRCNT_EN
    ,
    output logic [7:0]    err_cnt
`endif
);

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_PUSH  = 2'b01;
    localparam logic [1:0] OP_POP   = 2'b10;
    localparam logic [1:0] OP_ILL   = 2'b11;

    localparam logic [1:0] ERR_OK   = 2'b00;
    localparam logic [1:0] ERR_OVF  = 2'b01;
    localparam logic [1:0] ERR_UNF  = 2'b10;
    localparam logic [1:0] ERR_ILL  = 2'b11;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PUSH_ISS = 3'd1,
        POP_ISS  = 3'd2,
        POP_CAP  = 3'd3,
        RESP     = 3'd4
    } state_t;

    state_t        r_state;
    logic          r_cmd_ready;
    logic          r_push;
    logic          r_pop;
    logic [DW-1:0] r_data_in;
    logic          r_resp_valid;
    logic [DW-1:0] r_resp_data;
    logic [1:0]    r_resp_err;

    logic          w_accept;
    logic [1:0]    w_err_code;
    logic          w_err_enter;

    // Command acceptance and error classification of the offered command
    always_comb begin
        w_accept   = cmd_valid && r_cmd_ready && (r_state == IDLE);
        w_err_code = ERR_OK;
        case (cmd_op)
            OP_PUSH: if (Full)  w_err_code = ERR_OVF;
            OP_POP:  if (Empty) w_err_code = ERR_UNF;
            OP_ILL:  w_err_code = ERR_ILL;
            default: w_err_code = ERR_OK;
        endcase
        w_err_enter = w_accept && (w_err_code != ERR_OK);
    end

    // Main sequencer: state plus every registered output
    always_ff @(posedge clk or negedge RstN) begin
        if (!RstN) begin
            r_state      <= IDLE;
            r_cmd_ready  <= 1'b0;
            r_push       <= 1'b0;
            r_pop        <= 1'b0;
            r_data_in    <= '0;
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
            r_resp_err   <= ERR_OK;
        end else begin
            case (r_state)
                IDLE: begin
                    r_cmd_ready <= 1'b1;
                    if (w_accept) begin
                        if (w_err_code != ERR_OK) begin
                            // Rejected command: straight to response, no strobe
                            r_cmd_ready  <= 1'b0;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= w_err_code;
                            r_resp_data  <= '0;
                            r_state      <= RESP;
                        end else if (cmd_op == OP_PUSH) begin
                            r_cmd_ready <= 1'b0;
                            r_data_in   <= cmd_data;
                            r_push      <= 1'b1;
                            r_state     <= PUSH_ISS;
                        end else if (cmd_op == OP_POP) begin
                            r_cmd_ready <= 1'b0;
                            r_pop       <= 1'b1;
                            r_state     <= POP_ISS;
                        end
                        // An accepted NOP leaves everything untouched
                    end
                end

                PUSH_ISS: begin
                    r_push       <= 1'b0;
                    r_resp_valid <= 1'b1;
                    r_resp_err   <= ERR_OK;
                    r_resp_data  <= r_data_in;
                    r_state      <= RESP;
                end

                POP_ISS: begin
                    // The stack samples Pop at this edge; data follows next cycle
                    r_pop   <= 1'b0;
                    r_state <= POP_CAP;
                end

                POP_CAP: begin
                    r_resp_valid <= 1'b1;
                    r_resp_err   <= ERR_OK;
                    r_resp_data  <= Data_Out;
                    r_state      <= RESP;
                end

                RESP: begin
                    if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_cmd_ready  <= 1'b1;
                        r_state      <= IDLE;
                    end
                end

                default: begin
                    r_push       <= 1'b0;
                    r_pop        <= 1'b0;
                    r_resp_valid <= 1'b0;
                    r_cmd_ready  <= 1'b0;
                    r_state      <= IDLE;
                end
            endcase
        end
    end

`ifdef STACK_CMD_ERRCNT_EN
    logic [7:0] r_err_cnt;

    // Saturating count of responses carrying a non-zero error code
    always_ff @(posedge clk or negedge RstN) begin
        if (!RstN) begin
            r_err_cnt <= 8'd0;
        end else if (w_err_enter && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign err_cnt = r_err_cnt;
`else
    logic w_unused_err;
    assign w_unused_err = w_err_enter;
`endif

    assign cmd_ready  = r_cmd_ready;
    assign Push       = r_push;
    assign Pop        = r_pop;
    assign Data_In    = r_data_in;
    assign resp_valid = r_resp_valid;
    assign resp_data  = r_resp_data;
    assign resp_err   = r_resp_err;

endmodule

// File: tb/tb_stack_cmd_frontend.sv
// Bench for stack_cmd_frontend with an 8-deep behavioural stack attached.
// Expected responses are queued by the stimulus at command acceptance and
// checked by an independent monitor on every response handshake.
module tb_stack_cmd_frontend;

    logic       clk = 1'b0;
    logic       RstN;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_data;
    logic       resp_valid;
    logic       resp_ready;
    logic [7:0] resp_data;
    logic [1:0] resp_err;
    logic       Push;
    logic       Pop;
    logic [7:0] Data_In;
    logic [7:0] Data_Out;
    logic       Full;
    logic       Empty;
`ifdef STACK_CMD_ERRCNT_EN
    logic [7:0] err_cnt;
`endif

    int total = 0;
    int bad   = 0;

    logic [9:0] sb_q[$];

    stack_cmd_frontend #(.DW(8)) dut (
        .clk        (clk),
        .RstN       (RstN),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_data   (cmd_data),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .Push       (Push),
        .Pop        (Pop),
        .Data_In    (Data_In),
        .Data_Out   (Data_Out),
        .Full       (Full),
        .Empty      (Empty)
`ifdef STACK_CMD_ERRCNT_EN
        ,
        .err_cnt    (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural 8-deep stack: read data appears the cycle after Pop is sampled
    logic [7:0] mem [8];
    int         sp = 0;
    initial Data_Out = 8'h00;
    always @(posedge clk) begin
        if (Push && sp < 8) begin
            mem[sp] <= Data_In;
            sp      <= sp + 1;
        end
        if (Pop && sp > 0) begin
            Data_Out <= mem[sp-1];
            sp       <= sp - 1;
        end
    end
    assign Full  = (sp == 8);
    assign Empty = (sp == 0);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Response monitor / scoreboard
    always @(negedge clk) begin
        if (RstN) begin
            if (Push && Pop) chk("push_pop_overlap", 1, 0);
            if (resp_valid && resp_ready) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_resp", {22'd0, resp_err, resp_data}, 32'h3FF);
                end else begin
                    logic [9:0] e;
                    e = sb_q.pop_front();
                    chk("resp_err",  {30'd0, resp_err}, {30'd0, e[9:8]});
                    chk("resp_data", {24'd0, resp_data}, {24'd0, e[7:0]});
                end
            end
        end
    end

    // Offer a command, wait for acceptance, then check strobe timing
    task automatic send(input logic [1:0] op, input logic [7:0] d,
                        input logic [1:0] xerr, input logic [7:0] xdata);
        bit acc = 0;
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        for (int i = 0; i < 40 && !acc; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                @(posedge clk);
                acc = 1;
            end
        end
        #1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        if (!acc) begin
            chk("accept_timeout", 0, 1);
            return;
        end
        if (op != 2'b00) sb_q.push_back({xerr, xdata});
        @(negedge clk);
        if (op == 2'b00) begin
            chk("nop_ready", cmd_ready, 1);
            chk("nop_valid", resp_valid, 0);
            chk("nop_strobe", {Push, Pop}, 0);
        end else if (xerr != 2'b00) begin
            chk("err_no_strobe", {Push, Pop}, 0);
            chk("err_valid_1edge", resp_valid, 1);
        end else if (op == 2'b01) begin
            chk("push_strobe", Push, 1);
            chk("push_data_in", Data_In, d);
            chk("push_no_pop", Pop, 0);
            chk("push_valid_early", resp_valid, 0);
            @(negedge clk);
            chk("push_one_cycle", Push, 0);
            chk("push_valid", resp_valid, 1);
        end else begin
            chk("pop_strobe", Pop, 1);
            chk("pop_no_push", Push, 0);
            chk("pop_valid_e1", resp_valid, 0);
            @(negedge clk);
            chk("pop_one_cycle", Pop, 0);
            chk("pop_valid_e2", resp_valid, 0);
            @(negedge clk);
            chk("pop_valid", resp_valid, 1);
        end
    endtask

    initial begin
        RstN       = 1'b0;
        cmd_valid  = 1'b0;
        cmd_op     = 2'b00;
        cmd_data   = 8'h00;
        resp_ready = 1'b1;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_push", Push, 0);
        chk("rst_pop", Pop, 0);
        chk("rst_data_in", Data_In, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp", {resp_err, resp_data}, 0);
        chk("rst_cmd_ready", cmd_ready, 0);
        RstN = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_rst", cmd_ready, 1);

        // Basic push / pop
        send(2'b01, 8'h11, 2'b00, 8'h11);
        send(2'b01, 8'h5A, 2'b00, 8'h5A);
        send(2'b10, 8'h00, 2'b00, 8'h5A);
        send(2'b10, 8'h00, 2'b00, 8'h11);

        // Underflow, fill, overflow, drain
        send(2'b10, 8'h00, 2'b10, 8'h00);
        for (int i = 1; i <= 8; i++) send(2'b01, 8'(i), 2'b00, 8'(i));
        send(2'b01, 8'h09, 2'b01, 8'h00);
`ifdef STACK_CMD_ERRCNT_EN
        chk("err_cnt", err_cnt, 2);
`endif
        for (int i = 8; i >= 1; i--) send(2'b10, 8'h00, 2'b00, 8'(i));

        // Back-pressure: response held while resp_ready is low
        @(posedge clk); #1;
        resp_ready = 1'b0;
        send(2'b01, 8'h33, 2'b00, 8'h33);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_valid", resp_valid, 1);
            chk("hold_data", resp_data, 8'h33);
            chk("hold_err", resp_err, 0);
            chk("hold_cmd_ready", cmd_ready, 0);
        end
        @(posedge clk); #1;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        chk("hold_release_valid", resp_valid, 0);
        chk("hold_release_ready", cmd_ready, 1);
        send(2'b10, 8'h00, 2'b00, 8'h33);

        // NOP and illegal op
        send(2'b00, 8'hAA, 2'b00, 8'h00);
        send(2'b11, 8'hBB, 2'b11, 8'h00);

        // Reset during POP_ISS discards the command
        send(2'b01, 8'h77, 2'b00, 8'h77);
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_op    = 2'b10;
        for (int i = 0; i < 40 && !cmd_ready; i++) @(negedge clk);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        @(negedge clk);
        chk("rst_mid_pop_hi", Pop, 1);
        #1 RstN = 1'b0;
        #1 chk("rst_mid_pop_async", Pop, 0);
        chk("rst_mid_valid", resp_valid, 0);
        repeat (2) @(negedge clk);
        RstN = 1'b1;
        begin
            bit seen = 0;
            repeat (6) begin
                @(negedge clk);
                if (resp_valid) seen = 1;
            end
            chk("rst_no_resp", seen, 0);
        end
        send(2'b10, 8'h00, 2'b00, 8'h77);

        repeat (4) @(negedge clk);
        chk("sb_drain", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/stack_cmd_frontend.md
STACK_CMD_FRONTEND -- requirements
Module: stack_cmd_frontend

Interface
REQ-001 SHALL have parameter DW, default 8, the data width; it matches the stack data width.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port RstN  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port cmd_valid  input  1  a command is offered.
REQ-005 SHALL have port cmd_ready  output  1  the block accepts a command.
REQ-006 SHALL have port cmd_op  input  2  command: 00 NOP, 01 PUSH, 10 POP, 11 illegal.
REQ-007 SHALL have port cmd_data  input  DW  the PUSH operand.
REQ-008 SHALL have port resp_valid  output  1  a response is presented.
REQ-009 SHALL have port resp_ready  input  1  the consumer takes the response.
REQ-010 SHALL have port resp_data  output  DW  the popped value (POP), the echoed operand (PUSH), or 0 (error).
REQ-011 SHALL have port resp_err  output  2  00 ok, 01 overflow, 10 underflow, 11 illegal op.
REQ-012 SHALL have port Push  output  1  stack push strobe.
REQ-013 SHALL have port Pop  output  1  stack pop strobe.
REQ-014 SHALL have port Data_In  output  DW  stack write data.
REQ-015 SHALL have port Data_Out  input  DW  stack read data; valid the cycle after the edge that samples Pop.
REQ-016 SHALL have port Full  input  1  stack full flag.
REQ-017 SHALL have port Empty  input  1  stack empty flag.

Function
REQ-018 SHALL implement FSM states IDLE, PUSH_ISS, POP_ISS, POP_CAP, RESP.
REQ-019 SHALL drive cmd_ready=1 only in IDLE; a command is accepted at an edge where cmd_valid and cmd_ready are both 1.
REQ-020 SHALL, on an accepted NOP, remain in IDLE and produce no response and no strobe.
REQ-021 SHALL, on an accepted PUSH with Full=0 at the accept edge, register Data_In=cmd_data and Push=1, and enter PUSH_ISS.
REQ-022 SHALL, in PUSH_ISS, drive Push high for exactly one cycle, then enter RESP with resp_err=00 and resp_data=the operand.
REQ-023 SHALL, on an accepted POP with Empty=0, drive Pop=1 for exactly one cycle (POP_ISS), then wait in POP_CAP.
REQ-024 SHALL capture Data_Out into resp_data at the POP_CAP edge and enter RESP; resp_valid rises 2 edges after accept.
REQ-025 SHALL, on PUSH with Full=1, issue no Push and enter RESP at the next edge with resp_err=01 and resp_data=0.
REQ-026 SHALL, on POP with Empty=1, issue no Pop and enter RESP with resp_err=10 and resp_data=0.
REQ-027 SHALL, on op 11, enter RESP with resp_err=11 and resp_data=0, with no strobe.
REQ-028 SHALL hold resp_valid, resp_data and resp_err stable in RESP until resp_ready=1, then return to IDLE at that edge.
REQ-029 SHALL never assert Push and Pop in the same cycle.
REQ-030 SHALL drive Push, Pop, Data_In, resp_* from registers (no combinational input-to-output paths except none).

Reset
REQ-031 SHALL, while RstN=0, immediately force state=IDLE, Push=0, Pop=0, Data_In=0, resp_valid=0, resp_data=0, resp_err=00; cmd_ready=1 after the first edge with RstN=1.
REQ-032 SHALL discard an in-flight command on reset mid-operation, with no response generated afterwards.

Configuration
REQ-033 SHALL, with macro STACK_CMD_ERRCNT_EN defined, add output err_cnt [7:0] (reset 0) that increments on each edge entering RESP with resp_err!=00 and saturates at 255.
REQ-034 SHALL, without STACK_CMD_ERRCNT_EN, omit err_cnt and all its logic; other behaviour is identical.

Verification
REQ-035 SHALL cover: reset, then PUSH 0x11 with Full=0 -> Push=1 for one cycle with Data_In=0x11; resp ok with data 0x11.
REQ-036 SHALL cover: POP, with the stack returning 0x5A -> Pop is a one-cycle pulse; resp_valid 2 edges after accept; resp_data=0x5A, err=00.
REQ-037 SHALL cover: PUSH with Full=1 -> no Push; resp_err=01; POP with Empty=1 -> no Pop; resp_err=10; err_cnt=2 if enabled.
REQ-038 SHALL cover: resp_ready held 0 for 5 cycles -> response stable and cmd_ready=0 throughout; accepted on the cycle resp_ready=1.
REQ-039 SHALL cover: 8 PUSHes (1..8) into an 8-deep stack, then a 9th -> overflow; 8 POPs return 8..1 in order.
REQ-040 SHALL cover: RstN low during POP_ISS -> Pop drops asynchronously; no response; NOP and op 11 handled per REQ-020 and REQ-027.
